// File: rtl/locked_adder_scheduler.sv
// locked_adder_scheduler: loads the unlock key, then round-robin arbitrates two requesters onto the locked adder
module locked_adder_scheduler #(
    parameter int KEY_W  = 64,
    parameter int DATA_W = 32,
    parameter int BEAT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              key_valid_i,
    input  logic [BEAT_W-1:0] key_data_i,
    output logic              key_ready_o,
    output logic              key_loaded_o,
    input  logic              key_reload_i,
    input  logic              req0_valid_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    output logic              req1_ready_o,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [DATA_W:0]   rsp_sum_o,
    output logic [DATA_W-1:0] add1_o,
    output logic [DATA_W-1:0] add2_o,
    output logic [KEY_W-1:0]  keyinput_o,
    input  logic [DATA_W:0]   result_i
);
    localparam int BEATS = KEY_W / BEAT_W;
    localparam int CW = $clog2(BEATS);
    typedef enum logic [1:0] {LOAD, IDLE, EXEC, RESP} state_t;
    state_t            state;
    logic [CW-1:0]     cnt;
    logic              rr;
    logic [KEY_W-1:0]  key_reg;
    logic              issue;
    // rr=1 favours req1 when both are valid; reload suppresses any grant
    assign issue        = (state == IDLE) & ~key_reload_i;
    assign req0_ready_o = issue & req0_valid_i & (~req1_valid_i | ~rr);
    assign req1_ready_o = issue & req1_valid_i & (~req0_valid_i | rr);
    assign key_ready_o  = (state == LOAD);
    assign keyinput_o   = key_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= LOAD;
            cnt          <= '0;
            rr           <= 1'b0;
            key_reg      <= '0;
            key_loaded_o <= 1'b0;
            add1_o       <= '0;
            add2_o       <= '0;
            rsp_sum_o    <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= 1'b0;
        end else begin
            case (state)
                LOAD: if (key_valid_i) begin
                    key_reg[BEAT_W*cnt +: BEAT_W] <= key_data_i;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(BEATS - 1)) begin
                        key_loaded_o <= 1'b1;
                        state        <= IDLE;
                    end
                end
                IDLE: if (key_reload_i) begin
                    key_reg      <= '0;
                    key_loaded_o <= 1'b0;
                    cnt          <= '0;
                    state        <= LOAD;
                end else if (req0_ready_o | req1_ready_o) begin
                    add1_o   <= req1_ready_o ? req1_a_i : req0_a_i;
                    add2_o   <= req1_ready_o ? req1_b_i : req0_b_i;
                    rsp_id_o <= req1_ready_o;
                    rr       <= ~req1_ready_o;
                    state    <= EXEC;
                end
                EXEC: begin
                    rsp_sum_o   <= result_i;
                    rsp_valid_o <= 1'b1;
                    state       <= RESP;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_o <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule
